// File: rtl/lo_psync_monitor_pkg.sv
// Shared types and helpers for the LO phase-sync monitor: state codes, default widths
// and the wrapped signed phase-error function used by every channel.
package lo_psync_pkg;

    localparam int PW_DEF       = 10;
    localparam int AVG_LOG2_DEF = 4;
    localparam int ACC_W        = PW_DEF + AVG_LOG2_DEF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_CHECK  = 3'd3
    } state_e;

    // (lo - dig) mod 2^pw, returned sign-extended so a full turn maps to -2^(pw-1)..2^(pw-1)-1
    function automatic logic signed [31:0] wrap_err(input logic [31:0] lo,
                                                    input logic [31:0] dig,
                                                    input int          pw);
        logic [31:0] mask;
        logic [31:0] d;
        mask = (32'd1 << pw) - 32'd1;
        d    = (lo - dig) & mask;
        if (d[pw-1])
            d = d | ~mask;
        return $signed(d);
    endfunction

endpackage

// File: rtl/lo_psync_monitor_if.sv
// Sample/config/status bundle of the LO phase-sync monitor; the DUT side is the slave.
interface lo_psync_monitor_if #(
    parameter int NCH   = 2,
    parameter int PW    = 10,
    parameter int SET_W = 8
);
    logic                 EN;
    logic                 SMP_VLD;
    logic [NCH*PW-1:0]    LO_PHASE;
    logic [PW-1:0]        DIG_PHASE;
    logic [PW-2:0]        THR;
    logic [SET_W-1:0]     SETTLE_CYC;
    logic [NCH*PW-1:0]    AVG_PHE;
    logic                 AVG_VLD;
    logic [NCH-1:0]       LOCK;
    logic [2:0]           STATE;

    modport master (
        output EN, SMP_VLD, LO_PHASE, DIG_PHASE, THR, SETTLE_CYC,
        input  AVG_PHE, AVG_VLD, LOCK, STATE
    );

    modport slave (
        input  EN, SMP_VLD, LO_PHASE, DIG_PHASE, THR, SETTLE_CYC,
        output AVG_PHE, AVG_VLD, LOCK, STATE
    );
endinterface

// File: rtl/lo_psync_monitor_chacc.sv
// One LO channel: wrapped phase error, window accumulator, average register,
// |avg| threshold compare, consecutive-hit counter and LOCK flag.
module lo_psync_chacc
    import lo_psync_pkg::*;
#(
    parameter int PW       = 10,
    parameter int AVG_LOG2 = 4,
    parameter int LOCK_WIN = 3
) (
    input  logic          REF,
    input  logic          ARST,
    input  logic          clr,
    input  logic          add,
    input  logic          load,
    input  logic          check,
    input  logic [PW-1:0] lo,
    input  logic [PW-1:0] dig,
    input  logic [PW-2:0] thr,
    output logic [PW-1:0] avg,
    output logic          lock
);

    localparam int CW = PW + AVG_LOG2;
    localparam int HW = $clog2(LOCK_WIN + 1);

    logic signed [CW-1:0] err_ext;
    logic signed [CW-1:0] acc;
    logic signed [CW-1:0] sum;
    logic [PW-1:0]        avg_next;
    logic [PW-1:0]        avg_neg;
    logic [PW-2:0]        mag;
    logic                 in_thr;
    logic [HW-1:0]        hit;

    assign err_ext  = CW'(wrap_err(32'(lo), 32'(dig), PW));
    assign sum      = acc + err_ext;
    // Taking the upper PW bits is the arithmetic shift by AVG_LOG2 (floor toward -inf)
    assign avg_next = sum[CW-1:AVG_LOG2];
    assign avg_neg  = -avg_next;

    always_comb begin
        mag = avg_next[PW-2:0];
        if (avg_next[PW-1])
            mag = avg_neg[PW-1] ? '1 : avg_neg[PW-2:0];
    end

    assign in_thr = (mag <= thr);

    always_ff @(posedge REF or posedge ARST) begin
        if (ARST) begin
            acc  <= '0;
            avg  <= '0;
            hit  <= '0;
            lock <= 1'b0;
        end else if (clr) begin
            acc  <= '0;
            hit  <= '0;
            lock <= 1'b0;
        end else if (check) begin
            avg <= avg_next;
            acc <= '0;
            if (in_thr) begin
                if (hit != HW'(LOCK_WIN))
                    hit <= hit + HW'(1);
                if (hit >= HW'(LOCK_WIN - 1))
                    lock <= 1'b1;
            end else begin
                hit  <= '0;
                lock <= 1'b0;
            end
        end else if (load) begin
            acc <= err_ext;
        end else if (add) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/lo_psync_monitor.sv
// LO phase-sync monitor top: sequencing FSM, settle/sample counters, per-channel
// accumulators and output packing.
//
// state  | meaning
// IDLE   | disabled, channel state held cleared
// SETTLE | discarding the first SETTLE_CYC valid samples after enable
// ACCUM  | summing errors of the current 2^AVG_LOG2-sample window
// CHECK  | new average/LOCK visible, AVG_VLD high; a sample here opens the next window
module lo_psync_monitor
    import lo_psync_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int PW       = 10,
    parameter int AVG_LOG2 = 4,
    parameter int LOCK_WIN = 3,
    parameter int SET_W    = 8
) (
    input  logic               REF,
    input  logic               ARST,
    lo_psync_monitor_if.slave  bus
);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_SETTLE = ST_SETTLE;
    localparam logic [2:0] S_ACCUM  = ST_ACCUM;
    localparam logic [2:0] S_CHECK  = ST_CHECK;

    logic [2:0]          state;
    logic [SET_W-1:0]    settle_cnt;
    logic [SET_W:0]      settle_nxt;
    logic                settle_done;
    logic [AVG_LOG2-1:0] smp_cnt;
    logic                smp_last;
    logic                take;
    logic                clr;
    logic                add;
    logic                load;
    logic                check;
    logic [NCH*PW-1:0]   avg_pk;
    logic [NCH-1:0]      lock_v;

    assign settle_nxt  = {1'b0, settle_cnt} + (SET_W+1)'(1);
    // >= rather than == so a SETTLE_CYC lowered mid-settle cannot strand the FSM
    assign settle_done = (settle_nxt >= {1'b0, bus.SETTLE_CYC});
    assign smp_last    = (smp_cnt == '1);
    assign take        = bus.EN & bus.SMP_VLD;

    assign clr   = ~bus.EN | (state == S_IDLE);
    assign add   = take & (state == S_ACCUM) & ~smp_last;
    assign check = take & (state == S_ACCUM) &  smp_last;
    assign load  = take & (state == S_CHECK);

    always_ff @(posedge REF or posedge ARST) begin
        if (ARST) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            smp_cnt    <= '0;
        end else if (!bus.EN) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            smp_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    settle_cnt <= '0;
                    smp_cnt    <= '0;
                    state      <= (bus.SETTLE_CYC == '0) ? S_ACCUM : S_SETTLE;
                end
                S_SETTLE: begin
                    if (bus.SMP_VLD) begin
                        if (settle_done) begin
                            state   <= S_ACCUM;
                            smp_cnt <= '0;
                        end else begin
                            settle_cnt <= settle_nxt[SET_W-1:0];
                        end
                    end
                end
                S_ACCUM: begin
                    if (bus.SMP_VLD) begin
                        smp_cnt <= smp_cnt + AVG_LOG2'(1);
                        if (smp_last)
                            state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    state   <= S_ACCUM;
                    smp_cnt <= bus.SMP_VLD ? AVG_LOG2'(1) : '0;
                end
                default: begin
                    state      <= S_IDLE;
                    settle_cnt <= '0;
                    smp_cnt    <= '0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        lo_psync_chacc #(
            .PW       (PW),
            .AVG_LOG2 (AVG_LOG2),
            .LOCK_WIN (LOCK_WIN)
        ) u_chacc (
            .REF   (REF),
            .ARST  (ARST),
            .clr   (clr),
            .add   (add),
            .load  (load),
            .check (check),
            .lo    (bus.LO_PHASE[k*PW +: PW]),
            .dig   (bus.DIG_PHASE),
            .thr   (bus.THR),
            .avg   (avg_pk[k*PW +: PW]),
            .lock  (lock_v[k])
        );
    end

    assign bus.AVG_PHE = avg_pk;
    assign bus.AVG_VLD = (state == S_CHECK);
    assign bus.LOCK    = lock_v;
    assign bus.STATE   = state;

endmodule
